// File: rtl/ifu_fetch_pkg.sv
// Shared widths, FSM encoding, load payload and word select for the fetch unit.
// Latency: none (declarations only).
// Backpressure: n/a.
package ifu_fetch_pkg;

    localparam int IFU_ADDR_W = 64;
    localparam int IFU_INST_W = 32;
    localparam int IFU_BUS_W  = 64;

    localparam logic [IFU_INST_W-1:0] IFU_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2,
        IFU_DROP = 2'd3
    } ifu_state_e;

    // Payload handed from the FSM to the output register: PC plus raw bus word.
    typedef struct packed {
        logic [IFU_ADDR_W-1:0] pc;
        logic [IFU_BUS_W-1:0]  dat;
    } ifu_load_t;

    // The bus word carries two instructions; pc[2] picks the upper one.
    function automatic logic [IFU_INST_W-1:0] ifu_word_sel(input logic [IFU_BUS_W-1:0] dat,
                                                           input logic                  hi);
        return hi ? dat[IFU_BUS_W-1:IFU_INST_W] : dat[IFU_INST_W-1:0];
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundle of PC-generator, imem and ID-side signals of the fetch unit.
// Latency: none (wires only).
// Backpressure: carries pc_stall_o, imem_req_ready_i and id_ready_i.
// Optional: IFU_MISALIGN_EXC_EN adds if_misalign_o.
interface ifu_fetch_if;
    import ifu_fetch_pkg::*;

    logic                  pc_stall_o;
    logic [IFU_ADDR_W-1:0] pc_i;
    logic                  new_sign_i;
    logic                  flush_i;
    logic                  imem_req_valid_o;
    logic                  imem_req_ready_i;
    logic [IFU_ADDR_W-1:0] imem_req_addr_o;
    logic                  imem_resp_valid_i;
    logic [IFU_BUS_W-1:0]  imem_resp_data_i;
    logic                  if_valid_o;
    logic                  id_ready_i;
    logic [IFU_ADDR_W-1:0] if_pc_o;
    logic [IFU_INST_W-1:0] if_inst_o;
`ifdef IFU_MISALIGN_EXC_EN
    logic                  if_misalign_o;
`endif

    // Fetch unit side.
    modport master (
        input  pc_i, new_sign_i, flush_i, imem_req_ready_i, imem_resp_valid_i,
               imem_resp_data_i, id_ready_i,
        output pc_stall_o, imem_req_valid_o, imem_req_addr_o, if_valid_o, if_pc_o, if_inst_o
`ifdef IFU_MISALIGN_EXC_EN
        , output if_misalign_o
`endif
    );

    // Environment side: PC generator, instruction memory and ID.
    modport slave (
        output pc_i, new_sign_i, flush_i, imem_req_ready_i, imem_resp_valid_i,
               imem_resp_data_i, id_ready_i,
        input  pc_stall_o, imem_req_valid_o, imem_req_addr_o, if_valid_o, if_pc_o, if_inst_o
`ifdef IFU_MISALIGN_EXC_EN
        , input if_misalign_o
`endif
    );

endinterface

// File: rtl/ifu_fetch_resp_buf.sv
// Output register towards ID: word select of the response plus valid/ready hold.
// Latency: 1 cycle from load_vld_i to if_valid_o.
// Backpressure: holds data while id_ready_i is low; flush or handshake empties it.
// Optional: IFU_MISALIGN_EXC_EN adds the misalign flag alongside the data.
module ifu_resp_buf
    import ifu_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_vld_i,
    input  ifu_load_t             load_i,
`ifdef IFU_MISALIGN_EXC_EN
    input  logic                  load_misalign_i,
    output logic                  misalign_o,
`endif
    input  logic                  flush_i,
    input  logic                  id_ready_i,
    output logic                  if_valid_o,
    output logic [IFU_ADDR_W-1:0] if_pc_o,
    output logic [IFU_INST_W-1:0] if_inst_o
);

    logic                  valid_q, valid_d;
    logic [IFU_ADDR_W-1:0] pc_q, pc_d;
    logic [IFU_INST_W-1:0] inst_q, inst_d;
`ifdef IFU_MISALIGN_EXC_EN
    logic                  misalign_q, misalign_d;
`endif

    // New data wins over a same-cycle handshake; otherwise flush or handshake empties the slot.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
`ifdef IFU_MISALIGN_EXC_EN
        misalign_d = misalign_q;
`endif
        if (load_vld_i) begin
            valid_d = 1'b1;
            pc_d    = load_i.pc;
            inst_d  = ifu_word_sel(load_i.dat, load_i.pc[2]);
`ifdef IFU_MISALIGN_EXC_EN
            misalign_d = load_misalign_i;
`endif
        end else if (flush_i || id_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Output register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
`ifdef IFU_MISALIGN_EXC_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
`ifdef IFU_MISALIGN_EXC_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign if_valid_o = valid_q;
    assign if_pc_o    = pc_q;
    assign if_inst_o  = inst_q;
`ifdef IFU_MISALIGN_EXC_EN
    assign misalign_o = misalign_q;
`endif

endmodule

// File: rtl/ifu_fetch.sv
// Fetch unit: latches each new PC, issues one imem request, hands the instruction to ID.
// Latency: request 1 cycle after new_sign_i; if_valid_o 1 cycle after the response (3 best case).
// Backpressure: request held until imem_req_ready_i; pc_stall_o while busy or ID stalls.
// Optional: IFU_MISALIGN_EXC_EN reports PCs with pc_i[1:0]!=0 instead of fetching them.
module ifu_fetch
    import ifu_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus
);

    ifu_state_e            state_q, state_d;
    logic [IFU_ADDR_W-1:0] req_pc_q, req_pc_d;
    logic                  flush_seen_q, flush_seen_d;

    logic                  start;
    logic                  pc_misalign;
    logic                  mis_load;
    logic                  load_vld;
    ifu_load_t             load;
    logic                  if_valid;
    logic [IFU_ADDR_W-1:0] if_pc;
    logic [IFU_INST_W-1:0] if_inst;

    // A new PC is taken only when the output slot is free or being drained this cycle.
    assign start = bus.new_sign_i & ~bus.flush_i & (~if_valid | bus.id_ready_i);

`ifdef IFU_MISALIGN_EXC_EN
    assign pc_misalign = |bus.pc_i[1:0];
`else
    assign pc_misalign = 1'b0;
`endif

    assign mis_load = (state_q == IFU_IDLE) & start & pc_misalign;

    // FSM state and request PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IFU_IDLE;
            req_pc_q     <= '0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    // Next state: a request is never withdrawn, so a flush in REQ is remembered and
    // turns the eventual response into a drop.
    always_comb begin
        state_d      = state_q;
        req_pc_d     = req_pc_q;
        flush_seen_d = flush_seen_q;
        case (state_q)
            IFU_IDLE: begin
                if (start && !pc_misalign) begin
                    state_d      = IFU_REQ;
                    req_pc_d     = bus.pc_i;
                    flush_seen_d = 1'b0;
                end
            end
            IFU_REQ: begin
                if (bus.flush_i) flush_seen_d = 1'b1;
                if (bus.imem_req_ready_i)
                    state_d = (bus.flush_i || flush_seen_q) ? IFU_DROP : IFU_WAIT;
            end
            IFU_WAIT: begin
                if (bus.imem_resp_valid_i) state_d = IFU_IDLE;
                else if (bus.flush_i)      state_d = IFU_DROP;
            end
            IFU_DROP: begin
                if (bus.imem_resp_valid_i) state_d = IFU_IDLE;
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    // Outputs: imem request, stall, and what (if anything) loads the output register.
    always_comb begin
        bus.imem_req_valid_o = (state_q == IFU_REQ);
        bus.imem_req_addr_o  = {req_pc_q[IFU_ADDR_W-1:3], 3'b000};
        bus.pc_stall_o       = (state_q != IFU_IDLE) | (if_valid & ~bus.id_ready_i);
        load_vld             = 1'b0;
        load                 = '0;
        load.pc              = req_pc_q;
        load.dat             = bus.imem_resp_data_i;
        if (state_q == IFU_WAIT && bus.imem_resp_valid_i && !bus.flush_i) begin
            load_vld = 1'b1;
        end else if (mis_load) begin
            load_vld = 1'b1;
            load.pc  = bus.pc_i;
            load.dat = '0;
        end
    end

    ifu_resp_buf u_resp_buf (
        .clk             (clk),
        .rst             (rst),
        .load_vld_i      (load_vld),
        .load_i          (load),
`ifdef IFU_MISALIGN_EXC_EN
        .load_misalign_i (mis_load),
        .misalign_o      (bus.if_misalign_o),
`endif
        .flush_i         (bus.flush_i),
        .id_ready_i      (bus.id_ready_i),
        .if_valid_o      (if_valid),
        .if_pc_o         (if_pc),
        .if_inst_o       (if_inst)
    );

    assign bus.if_valid_o = if_valid;
    assign bus.if_pc_o    = if_pc;
    assign bus.if_inst_o  = if_inst;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed fetches, then random traffic against a transaction model.
// Latency: model tracks one outstanding fetch and the ID-side output slot per cycle.
// Backpressure: random imem ready, response delay 1..3, ID ready and flush.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_fetch_if bus ();

    ifu_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction memory: fixed contents for the directed part, address hash otherwise.
    bit          fixed_mem   = 1'b1;
    int          mem_dly_max = 1;
    int          mem_cnt     = 0;
    logic [63:0] mem_addr    = '0;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (fixed_mem) return 64'h0010_0093_0000_0513;
        return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0] + 32'h11};
    endfunction

    function automatic logic [31:0] exp_inst(input logic [63:0] pc);
        logic [63:0] w;
        w = mem_word({pc[63:3], 3'b000});
        return pc[2] ? w[63:32] : w[31:0];
    endfunction

    function automatic logic [63:0] rand_pc();
        logic [63:0] p;
        p      = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
        p[1:0] = 2'($urandom_range(0, 3));
        return p;
    endfunction

    // One cycle of stimulus, applied just after the rising edge.
    task automatic drive(input bit ns, input logic [63:0] pc, input bit fl, input bit rr, input bit ir);
        @(posedge clk);
        #1;
        bus.new_sign_i        = ns;
        bus.pc_i              = pc;
        bus.flush_i           = fl;
        bus.imem_req_ready_i  = rr;
        bus.id_ready_i        = ir;
        bus.imem_resp_valid_i = (mem_cnt == 1);
        bus.imem_resp_data_i  = (mem_cnt == 1) ? mem_word(mem_addr) : {$urandom, $urandom};
    endtask

    // Transaction model: one fetch in flight (killed by any later flush) plus the ID slot.
    bit          m_active, m_req_pend, m_killed, m_out_vld, m_out_mis;
    logic [63:0] m_req_pc, m_out_pc;
    logic [31:0] m_out_inst;
    bit          t_hs, t_acc, t_acc_mis, t_ld, t_ld_mis;
    logic [63:0] t_ld_pc;
    logic [31:0] t_ld_inst;

    always @(negedge clk) begin
        if (rst) begin
            m_active = 0; m_req_pend = 0; m_killed = 0; m_out_vld = 0; m_out_mis = 0;
            m_req_pc = '0; m_out_pc = '0; m_out_inst = '0;
            mem_cnt  = 0;
        end else begin
            check_eq("pc_stall", 64'(bus.pc_stall_o), 64'(m_active | (m_out_vld & ~bus.id_ready_i)));
            check_eq("req_valid", 64'(bus.imem_req_valid_o), 64'(m_req_pend));
            if (m_req_pend) check_eq("req_addr", bus.imem_req_addr_o, {m_req_pc[63:3], 3'b000});
            check_eq("if_valid", 64'(bus.if_valid_o), 64'(m_out_vld));
            if (m_out_vld) begin
                check_eq("if_pc", bus.if_pc_o, m_out_pc);
                check_eq("if_inst", 64'(bus.if_inst_o), 64'(m_out_inst));
`ifdef IFU_MISALIGN_EXC_EN
                check_eq("if_misalign", 64'(bus.if_misalign_o), 64'(m_out_mis));
`endif
            end

            // memory side: accept the request and schedule its single response
            if (mem_cnt > 0) mem_cnt--;
            if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
                mem_cnt  = $urandom_range(1, mem_dly_max);
                mem_addr = bus.imem_req_addr_o;
            end

            t_hs      = m_out_vld & bus.id_ready_i;
            t_acc     = bus.new_sign_i & ~bus.flush_i & ~m_active & (~m_out_vld | bus.id_ready_i);
            t_acc_mis = 1'b0;
`ifdef IFU_MISALIGN_EXC_EN
            t_acc_mis = t_acc && (bus.pc_i[1:0] != 2'b00);
`endif
            t_ld = 1'b0; t_ld_mis = 1'b0; t_ld_pc = '0; t_ld_inst = '0;
            if (m_active) begin
                if (bus.flush_i) m_killed = 1'b1;
                if (m_req_pend && bus.imem_req_ready_i) m_req_pend = 1'b0;
                if (bus.imem_resp_valid_i) begin
                    m_active = 1'b0;
                    if (!m_killed) begin
                        t_ld = 1'b1; t_ld_pc = m_req_pc; t_ld_inst = exp_inst(m_req_pc);
                    end
                end
            end else if (t_acc_mis) begin
                t_ld = 1'b1; t_ld_pc = bus.pc_i; t_ld_inst = '0; t_ld_mis = 1'b1;
            end else if (t_acc) begin
                m_active = 1'b1; m_req_pend = 1'b1; m_req_pc = bus.pc_i; m_killed = 1'b0;
            end

            if (t_ld) begin
                m_out_vld = 1'b1; m_out_pc = t_ld_pc; m_out_inst = t_ld_inst; m_out_mis = t_ld_mis;
            end else if (bus.flush_i || t_hs) begin
                m_out_vld = 1'b0;
            end
        end
    end

    // Best-case fetch with immediate ready and one-cycle response; explicit timing checks.
    task automatic directed_fetch(input string tag, input logic [63:0] pc,
                                  input logic [63:0] exp_addr, input logic [31:0] inst);
        drive(1, pc, 0, 1, 1);
        drive(0, '0, 0, 1, 1);
        @(negedge clk);
        check_eq({tag, "_req_vld_c1"}, 64'(bus.imem_req_valid_o), 64'd1);
        check_eq({tag, "_addr_c1"}, bus.imem_req_addr_o, exp_addr);
        drive(0, '0, 0, 1, 1);
        @(negedge clk);
        check_eq({tag, "_vld_c2"}, 64'(bus.if_valid_o), 64'd0);
        drive(0, '0, 0, 1, 1);
        @(negedge clk);
        check_eq({tag, "_vld_c3"}, 64'(bus.if_valid_o), 64'd1);
        check_eq({tag, "_pc_c3"}, bus.if_pc_o, pc);
        check_eq({tag, "_inst_c3"}, 64'(bus.if_inst_o), 64'(inst));
        drive(0, '0, 0, 1, 1);
    endtask

    initial begin
        bus.new_sign_i = 0; bus.pc_i = '0; bus.flush_i = 0; bus.imem_req_ready_i = 0;
        bus.id_ready_i = 0; bus.imem_resp_valid_i = 0; bus.imem_resp_data_i = '0;

        repeat (3) drive(0, '0, 0, 0, 0);
        @(negedge clk);
        check_eq("rst_stall", 64'(bus.pc_stall_o), 64'd0);
        check_eq("rst_req_vld", 64'(bus.imem_req_valid_o), 64'd0);
        check_eq("rst_req_addr", bus.imem_req_addr_o, 64'd0);
        check_eq("rst_if_vld", 64'(bus.if_valid_o), 64'd0);
        check_eq("rst_if_pc", bus.if_pc_o, 64'd0);
        check_eq("rst_if_inst", 64'(bus.if_inst_o), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, '0, 0, 1, 1);

        directed_fetch("lo_word", 64'h8000_0000, 64'h8000_0000, 32'h0000_0513);
        directed_fetch("hi_word", 64'h8000_0004, 64'h8000_0000, 32'h0010_0093);

        // imem not ready for 4 cycles: request held stable, PC generator stalled
        drive(1, 64'h8000_0014, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, 0, 0, 1);
            @(negedge clk);
            check_eq("hold_req_vld", 64'(bus.imem_req_valid_o), 64'd1);
            check_eq("hold_addr", bus.imem_req_addr_o, 64'h8000_0010);
            check_eq("hold_stall", 64'(bus.pc_stall_o), 64'd1);
        end
        repeat (5) drive(0, '0, 0, 1, 1);

        // random traffic checked cycle by cycle against the model
        fixed_mem   = 1'b0;
        mem_dly_max = 3;
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 9) < 6, rand_pc(), $urandom_range(0, 11) == 0,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7);
        end
        repeat (10) drive(0, '0, 0, 1, 1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
